// File: rtl/ysyx_axi_rr_arbiter.sv
// Round-robin N-master to single AXI4 port arbiter, single-beat transfers.
// Optional response watchdog enabled by defining YSYX_BUS_TIMEOUT_EN.
module ysyx_axi_rr_arbiter #(
   parameter int NUM_M   = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_M-1:0]         m_req,
   input  logic [NUM_M-1:0]         m_we,
   input  logic [NUM_M*ADDR_W-1:0]  m_addr,
   input  logic [NUM_M*DATA_W-1:0]  m_wdata,
   input  logic [NUM_M*4-1:0]       m_strb,
   output logic [NUM_M-1:0]         m_done,
   output logic [DATA_W-1:0]        m_rdata,
   output logic                     m_err,
   output logic [NUM_M-1:0]         grant,
   output logic                     io_master_arvalid,
   input  logic                     io_master_arready,
   output logic [ADDR_W-1:0]        io_master_araddr,
   output logic [3:0]               io_master_arid,
   output logic [7:0]               io_master_arlen,
   output logic [2:0]               io_master_arsize,
   output logic [1:0]               io_master_arburst,
   input  logic                     io_master_rvalid,
   output logic                     io_master_rready,
   input  logic [1:0]               io_master_rresp,
   input  logic [63:0]              io_master_rdata,
   input  logic                     io_master_rlast,
   input  logic [3:0]               io_master_rid,
   output logic                     io_master_awvalid,
   input  logic                     io_master_awready,
   output logic [ADDR_W-1:0]        io_master_awaddr,
   output logic [3:0]               io_master_awid,
   output logic [7:0]               io_master_awlen,
   output logic [2:0]               io_master_awsize,
   output logic [1:0]               io_master_awburst,
   output logic                     io_master_wvalid,
   input  logic                     io_master_wready,
   output logic [63:0]              io_master_wdata,
   output logic [7:0]               io_master_wstrb,
   output logic                     io_master_wlast,
   input  logic                     io_master_bvalid,
   output logic                     io_master_bready,
   input  logic [1:0]               io_master_bresp,
   input  logic [3:0]               io_master_bid
);

   localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   typedef enum logic [2:0] {
      IDLE, RADDR, RDATA, WREQ, WRESP
   } state_t;

   state_t              state, nxt;
   logic [PW-1:0]       ptr, win, pick;
   logic                any;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wd;
   logic [3:0]          lat_strb;
   logic                aw_ok, w_ok;
   logic                rd_fin, wr_fin, fin;
   logic                to_hit, tmo;
   logic [2:0]          size;
   logic                unused;

   assign unused = ^{io_master_rlast, io_master_rid, io_master_bid};

   // First requester at or after the rotating pointer.
   always_comb begin
      int j;
      any  = 1'b0;
      pick = '0;
      j    = 0;
      for (int i = 0; i < NUM_M; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_M) j = j - NUM_M;
         if (!any && m_req[j]) begin
            any  = 1'b1;
            pick = PW'(j);
         end
      end
   end

   assign rd_fin = (state == RDATA) && io_master_rvalid;
   assign wr_fin = (state == WRESP) && io_master_bvalid;
   assign fin    = rd_fin || wr_fin;

`ifdef YSYX_BUS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || state == IDLE) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
   end

   assign to_hit = (state != IDLE) && (cnt == CW'(TIMEOUT - 1));
`else
   assign to_hit = 1'b0;
`endif

   // A genuine completion in the same cycle beats the watchdog.
   assign tmo = to_hit && !fin;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (any) nxt = m_we[pick] ? WREQ : RADDR;
         RADDR: if (io_master_arready) nxt = RDATA;
         RDATA: if (io_master_rvalid) nxt = IDLE;
         WREQ:  if ((aw_ok || io_master_awready) &&
                    (w_ok || io_master_wready)) nxt = WRESP;
         WRESP: if (io_master_bvalid) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (tmo) nxt = IDLE;
   end

   always_comb begin
      io_master_arvalid = 1'b0;
      io_master_rready  = 1'b0;
      io_master_awvalid = 1'b0;
      io_master_wvalid  = 1'b0;
      io_master_bready  = 1'b0;
      grant             = '0;
      if (state != IDLE) grant[win] = 1'b1;
      unique case (state)
         RADDR: io_master_arvalid = 1'b1;
         RDATA: io_master_rready  = 1'b1;
         WREQ: begin
            io_master_awvalid = !aw_ok;
            io_master_wvalid  = !w_ok;
         end
         WRESP: io_master_bready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         win      <= '0;
         lat_addr <= '0;
         lat_wd   <= '0;
         lat_strb <= '0;
         aw_ok    <= 1'b0;
         w_ok     <= 1'b0;
         m_done   <= '0;
         m_err    <= 1'b0;
         m_rdata  <= '0;
      end else begin
         m_done <= '0;
         if (state == IDLE) begin
            aw_ok <= 1'b0;
            w_ok  <= 1'b0;
            if (any) begin
               win      <= pick;
               lat_addr <= m_addr[pick*ADDR_W +: ADDR_W];
               lat_wd   <= m_wdata[pick*DATA_W +: DATA_W];
               lat_strb <= m_strb[pick*4 +: 4];
            end
         end
         if (state == WREQ) begin
            if (io_master_awvalid && io_master_awready) aw_ok <= 1'b1;
            if (io_master_wvalid && io_master_wready)   w_ok  <= 1'b1;
         end
         if (fin || tmo) begin
            m_done[win] <= 1'b1;
            ptr <= (win == PW'(NUM_M - 1)) ? '0 : win + 1'b1;
         end
         if (rd_fin) begin
            m_rdata <= lat_addr[2] ? io_master_rdata[63:32]
                                   : io_master_rdata[31:0];
            m_err   <= |io_master_rresp;
         end else if (wr_fin) begin
            m_err <= |io_master_bresp;
         end else if (tmo) begin
            m_err   <= 1'b1;
            m_rdata <= '0;
         end
      end
   end

   always_comb begin
      case (lat_strb)
         4'h1:    size = 3'd0;
         4'h3:    size = 3'd1;
         default: size = 3'd2;
      endcase
   end

   assign io_master_araddr  = lat_addr;
   assign io_master_arid    = 4'(win);
   assign io_master_arlen   = 8'd0;
   assign io_master_arsize  = size;
   assign io_master_arburst = 2'b01;

   assign io_master_awaddr  = lat_addr;
   assign io_master_awid    = 4'(win);
   assign io_master_awlen   = 8'd0;
   assign io_master_awsize  = size;
   assign io_master_awburst = 2'b01;

   assign io_master_wdata = {lat_wd, lat_wd};
   assign io_master_wstrb = lat_addr[2] ? {lat_strb, 4'b0}
                                        : {4'b0, lat_strb};
   assign io_master_wlast = 1'b1;

endmodule

// File: tb/tb_ysyx_axi_rr_arbiter.sv
// Randomized bench for ysyx_axi_rr_arbiter: AXI slave with random
// delays, request model tracking the round-robin pointer.
module tb_ysyx_axi_rr_arbiter;

   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef YSYX_BUS_TIMEOUT_EN
   localparam int TO = 15;
`else
   localparam int TO = 1023;
`endif

   logic clk, rst;
   logic [NM-1:0]    m_req, m_we, m_done, grant;
   logic [NM*AW-1:0] m_addr;
   logic [NM*DW-1:0] m_wdata;
   logic [NM*4-1:0]  m_strb;
   logic [DW-1:0]    m_rdata;
   logic             m_err;

   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] araddr, awaddr;
   logic [3:0]  arid, rid, awid, bid;
   logic [7:0]  arlen, awlen, wstrb;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic [63:0] rdata, wdata;
   logic        awvalid, awready, wvalid, wready, wlast;
   logic        bvalid, bready;

   ysyx_axi_rr_arbiter #(
      .NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_strb(m_strb),
      .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
      .grant(grant),
      .io_master_arvalid(arvalid), .io_master_arready(arready),
      .io_master_araddr(araddr), .io_master_arid(arid),
      .io_master_arlen(arlen), .io_master_arsize(arsize),
      .io_master_arburst(arburst),
      .io_master_rvalid(rvalid), .io_master_rready(rready),
      .io_master_rresp(rresp), .io_master_rdata(rdata),
      .io_master_rlast(rlast), .io_master_rid(rid),
      .io_master_awvalid(awvalid), .io_master_awready(awready),
      .io_master_awaddr(awaddr), .io_master_awid(awid),
      .io_master_awlen(awlen), .io_master_awsize(awsize),
      .io_master_awburst(awburst),
      .io_master_wvalid(wvalid), .io_master_wready(wready),
      .io_master_wdata(wdata), .io_master_wstrb(wstrb),
      .io_master_wlast(wlast),
      .io_master_bvalid(bvalid), .io_master_bready(bready),
      .io_master_bresp(bresp), .io_master_bid(bid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- AXI slave ----------------
   bit          stall_ar = 0, stall_r = 0;
   logic [31:0] c_araddr, c_awaddr;
   logic [3:0]  c_arid, c_awid;
   logic [7:0]  c_arlen, c_awlen, c_wstrb;
   logic [2:0]  c_arsize, c_awsize;
   logic [1:0]  c_arburst, c_awburst, s_rresp, s_bresp;
   logic [63:0] c_wdata, s_rdata;
   logic        c_wlast;

   initial begin
      bit r_hs, rph;
      int rdly;
      r_hs = 0; rph = 0; rdly = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      rlast = 0; rid = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            arready = 0; rvalid = 0; rph = 0; r_hs = 0;
         end else begin
            if (r_hs) begin rvalid = 0; rph = 0; end
            if (!rph) begin
               arready = !stall_ar && ($urandom_range(0, 3) != 0);
               if (arvalid && arready) begin
                  c_araddr = araddr; c_arid = arid;
                  c_arlen = arlen; c_arsize = arsize;
                  c_arburst = arburst;
                  rph = 1; rdly = $urandom_range(0, 3);
               end
            end else begin
               arready = 0;
               if (!rvalid && !stall_r) begin
                  if (rdly == 0) begin
                     rdata = {$urandom, $urandom};
                     rresp = ($urandom_range(0, 3) == 0)
                           ? 2'($urandom_range(1, 3)) : 2'b00;
                     rlast = 1; rid = c_arid; rvalid = 1;
                     s_rdata = rdata; s_rresp = rresp;
                  end else rdly--;
               end
            end
            r_hs = rvalid && rready;
         end
      end
   end

   initial begin
      bit b_hs, wph, aw_got, w_got;
      int bdly;
      b_hs = 0; wph = 0; aw_got = 0; w_got = 0; bdly = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0;
            b_hs = 0; wph = 0; aw_got = 0; w_got = 0;
         end else begin
            if (b_hs) begin bvalid = 0; wph = 0; end
            if (!wph) begin
               awready = !aw_got && ($urandom_range(0, 3) != 0);
               wready  = !w_got && ($urandom_range(0, 3) != 0);
               if (awvalid && awready) begin
                  c_awaddr = awaddr; c_awid = awid;
                  c_awlen = awlen; c_awsize = awsize;
                  c_awburst = awburst; aw_got = 1;
               end
               if (wvalid && wready) begin
                  c_wdata = wdata; c_wstrb = wstrb;
                  c_wlast = wlast; w_got = 1;
               end
               if (aw_got && w_got) begin
                  wph = 1; bdly = $urandom_range(0, 3);
               end
            end else begin
               awready = 0; wready = 0;
               if (!bvalid) begin
                  if (bdly == 0) begin
                     bresp = ($urandom_range(0, 3) == 0)
                           ? 2'($urandom_range(1, 3)) : 2'b00;
                     bid = c_awid; bvalid = 1;
                     s_bresp = bresp; aw_got = 0; w_got = 0;
                  end else bdly--;
               end
            end
            b_hs = bvalid && bready;
         end
      end
   end

   // ---------------- request model ----------------
   bit          pend [NM];
   logic        p_we [NM];
   logic [31:0] p_addr [NM];
   logic [31:0] p_wd [NM];
   logic [3:0]  p_strb [NM];
   logic [3:0]  stbl [5] = '{4'h1, 4'h3, 4'hf, 4'h2, 4'hc};
   int          ptr = 0;

   task automatic apply();
      for (int i = 0; i < NM; i++) begin
         m_req[i] = pend[i];
         m_we[i]  = p_we[i];
         m_addr[i*AW +: AW]  = p_addr[i];
         m_wdata[i*DW +: DW] = p_wd[i];
         m_strb[i*4 +: 4]    = p_strb[i];
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < NM; k++) begin
         int j;
         j = (ptr + k) % NM;
         if (pend[j]) return j;
      end
      return 0;
   endfunction

   function automatic logic [2:0] exp_size(input logic [3:0] s);
      if (s == 4'h1) return 3'd0;
      if (s == 4'h3) return 3'd1;
      return 3'd2;
   endfunction

   task automatic new_req(input int i);
      pend[i]   = 1;
      p_we[i]   = 1'($urandom_range(0, 1));
      p_addr[i] = $urandom;
      p_wd[i]   = $urandom;
      p_strb[i] = stbl[$urandom_range(0, 4)];
   endtask

   task automatic gen_new(input bit all);
      bit any;
      any = 0;
      for (int i = 0; i < NM; i++) begin
         if (!pend[i] && (all || $urandom_range(0, 1) == 1))
            new_req(i);
         any = any | pend[i];
      end
      if (!any) new_req($urandom_range(0, NM - 1));
   endtask

   task automatic wait_done(output bit ok);
      ok = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (m_done != 0) begin ok = 1; break; end
      end
   endtask

   task automatic check_txn(input int w);
      logic [31:0] a;
      logic [3:0]  s;
      a = p_addr[w];
      s = p_strb[w];
      check("done_onehot", 64'(m_done), 64'd1 << w);
      if (!p_we[w]) begin
         check("araddr", 64'(c_araddr), 64'(a));
         check("arid", 64'(c_arid), 64'(w));
         check("arsize", 64'(c_arsize), 64'(exp_size(s)));
         check("ar_len_burst", 64'({c_arlen, c_arburst}),
               64'({8'd0, 2'b01}));
         check("rdata_lane", 64'(m_rdata),
               64'(a[2] ? s_rdata[63:32] : s_rdata[31:0]));
         check("r_err", 64'(m_err), 64'(s_rresp != 2'b00));
      end else begin
         check("awaddr", 64'(c_awaddr), 64'(a));
         check("awid", 64'(c_awid), 64'(w));
         check("awsize", 64'(c_awsize), 64'(exp_size(s)));
         check("aw_len_burst", 64'({c_awlen, c_awburst}),
               64'({8'd0, 2'b01}));
         check("wdata", c_wdata, {p_wd[w], p_wd[w]});
         check("wstrb", 64'(c_wstrb),
               64'(a[2] ? {s, 4'b0} : {4'b0, s}));
         check("wlast", 64'(c_wlast), 64'd1);
         check("b_err", 64'(m_err), 64'(s_bresp != 2'b00));
      end
   endtask

   initial begin
      bit ok;
      int w, st, dc;
      rst = 1;
      for (int i = 0; i < NM; i++) begin
         pend[i] = 0; p_we[i] = 0; p_addr[i] = 0;
         p_wd[i] = 0; p_strb[i] = 0;
      end
      apply();
      repeat (3) @(negedge clk);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_done", 64'(m_done), 64'd0);
      check("rst_err_rdata", 64'({m_err, m_rdata}), 64'd0);
      check("rst_chan", 64'({arvalid, awvalid, wvalid, rready, bready}),
            64'd0);
      rst = 0;
      @(negedge clk);

`ifdef YSYX_BUS_TIMEOUT_EN
      stall_ar = 1;
      pend[0] = 1; p_we[0] = 0; p_addr[0] = 32'h8000_0004;
      p_wd[0] = 0; p_strb[0] = 4'hf;
      apply();
      st = -1; dc = 0; ok = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (arvalid && st < 0) st = c;
         if (m_done != 0) begin ok = 1; dc = c; break; end
      end
      check("to_seen", 64'(ok), 64'd1);
      check("to_latency", 64'(dc - st), 64'd15);
      check("to_done", 64'(m_done), 64'd1);
      check("to_err", 64'(m_err), 64'd1);
      check("to_rdata", 64'(m_rdata), 64'd0);
      check("to_arvalid", 64'(arvalid), 64'd0);
      pend[0] = 0; apply(); ptr = 1;
      stall_ar = 0;
      @(negedge clk);
`endif

      // Reset while the data phase is outstanding.
      stall_r = 1;
      new_req(1); p_we[1] = 0; apply();
      ok = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (rready) begin ok = 1; break; end
      end
      check("rst_reach_rdata", 64'(ok), 64'd1);
      rst = 1;
      pend[1] = 0; apply();
      @(negedge clk);
      check("mid_rst_grant", 64'(grant), 64'd0);
      check("mid_rst_arvalid", 64'(arvalid), 64'd0);
      check("mid_rst_rready", 64'(rready), 64'd0);
      @(negedge clk);
      rst = 0; stall_r = 0; ptr = 0;

      // First transaction: the documented single read on master 0.
      pend[0] = 1; p_we[0] = 0; p_addr[0] = 32'h8000_0004;
      p_wd[0] = 0; p_strb[0] = 4'hf;
      gen_new(1);
      apply();
      for (int t = 0; t < 60; t++) begin
         w = pick();
         @(negedge clk);
         check("arb_grant", 64'(grant), 64'd1 << w);
         check("done_pulse", 64'(m_done), 64'd0);
         wait_done(ok);
         if (!ok) begin
            check("done_wait", 64'd0, 64'd1);
            break;
         end
         check_txn(w);
         ptr = (w + 1) % NM;
         pend[w] = 0;
         gen_new(t < 4);
         apply();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_axi_rr_arbiter.md
Name: ysyx_axi_rr_arbiter

Overview:
- Parametrised N-master to 1 AXI4 master-port arbiter.
- Serves the IFU, LSU and future requesters (DMA, debug) through a uniform per-master request/response interface.
- Grants one transaction at a time by round-robin and drives single-beat AXI4 reads or writes on a 64-bit bus.
- Returns lane-extracted data and error status to the granted master, with an optional response-timeout watchdog.

Parameters:
- NUM_M, 2, number of requesting masters (1..8); master 0 has the highest priority after reset.
- ADDR_W, 32, address width.
- DATA_W, 32, master-side data width; the AXI data width is fixed at 64.
- TIMEOUT, 1023, watchdog cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_req  in  NUM_M  per-master request valid; held until m_done
- m_we  in  NUM_M  1 = write, 0 = read
- m_addr  in  NUM_M*ADDR_W  packed byte addresses
- m_wdata  in  NUM_M*DATA_W  packed write data, byte-lane aligned to addr[1:0]
- m_strb  in  NUM_M*4  packed byte strobes: 1, 3 or f
- m_done  out  NUM_M  one-cycle completion pulse per master
- m_rdata  out  DATA_W  read data; valid while m_done
- m_err  out  1  completion carries error; valid while m_done
- grant  out  NUM_M  one-hot current owner; 0 when idle
- io_master_ar{valid,addr,id,len,size,burst}, arready  out/in  AXI4 read address channel
- io_master_r{valid,data[63:0],resp,last,id}, rready  in/out  AXI4 read data channel
- io_master_aw{valid,addr,id,len,size,burst}, awready  out/in  AXI4 write address channel
- io_master_w{valid,data[63:0],strb[7:0],last}, wready  out/in  AXI4 write data channel
- io_master_b{valid,resp,id}, bready  in/out  AXI4 write response channel

Behaviour:
- Reset: state IDLE; rr pointer = 0; grant = 0; m_done = 0; m_err = 0; m_rdata = 0; all AXI valids = 0; rready = bready = 0.
- States: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE: if any m_req, pick the first requester at or after the pointer (wrapping modulo NUM_M), latch its addr, wdata, strb and we, set grant, and go to RADDR or WREQ on the next cycle. Arbitration costs 1 cycle.
- Round robin: on completion, pointer = winner+1, wrapping from NUM_M-1 to 0.
- RADDR: arvalid = 1 until arready, then go to RDATA. araddr is the latched address.
- RDATA: rready = 1. On rvalid, set m_rdata = addr[2] ? rdata[63:32] : rdata[31:0]; m_done[winner] = 1 for one cycle; m_err = (rresp != 0); return to IDLE.
- WREQ: awvalid and wvalid asserted together; each deasserts independently after its own handshake (either order, or the same cycle). Go to WRESP once both have completed.
- Write data lanes: wdata = {wd, wd}; wstrb = addr[2] ? {strb, 4'b0} : {4'b0, strb}; wlast = 1.
- WRESP: bready = 1. On bvalid, pulse m_done; m_err = (bresp != 0); return to IDLE.
- AXI constants: len = 0, burst = INCR (01), id = winner index. size = 0, 1 or 2 for strb 1, 3 or f; any other strb uses size 2.
- AXI outputs are stable while valid is high and not yet accepted.
- The latched request is used for the whole transaction; m_req changing mid-transaction is ignored.
- A master must not deassert m_req before m_done.
- Request in the same cycle as m_done: the owning master may re-request but is arbitrated normally and loses to any pending higher-rotated requester.
- NUM_M = 1: the pointer stays 0.
- rst mid-transaction returns to IDLE immediately. The AXI slave is responsible for its own reset.

Optional Feature:
- Macro: YSYX_BUS_TIMEOUT_EN.
- When defined: a counter clears on entry to RADDR/WREQ and increments each non-IDLE cycle. On reaching TIMEOUT, pulse m_done with m_err = 1 and m_rdata = 0, drop all valids and readies, and return to IDLE.
- When undefined: no counter; the block waits indefinitely.

Test Plan:
- Single read: m_req[0], addr 0x8000_0004, strb f; slave returns rdata 0x11223344_55667788 -> araddr 0x8000_0004, arsize 2, arid 0; m_rdata 0x11223344, m_done[0] 1 cycle, m_err 0.
- Byte write: master 1, addr 0x1000_0001, wdata 0x0000_4100, strb 2; awready 2 cycles before wready -> wstrb 0x02, wdata 0x00004100_00004100; m_done[1] after bvalid.
- Contention: m_req = 2'b11 held continuously -> grants alternate 01, 10, 01, 10 over 4 transactions.
- Error: rresp = 2'b10 -> m_done with m_err = 1. Repeat with bresp = 2'b11 -> same.
- Reset while in RDATA -> next cycle grant 0, arvalid 0, rready 0; a new request is served normally afterwards.
- Timeout (macro on, TIMEOUT = 15): arready held 0 -> m_done with m_err = 1 exactly 15 cycles after arvalid rises; arvalid then 0.
